// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle key strobe.
// Optional macro KEYPAD_COLSYNC_EN inserts a two-flop synchronizer on the column inputs.
module keypad_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keypadCol,
   output logic [3:0] keypadRow,
   output logic [3:0] keypadBuf,
   output logic       key_valid,
   output logic       key_down
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_DONE    = CW'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      S_SCAN,
      S_PRESS_DB,
      S_HOLD,
      S_REL_DB
   } state_t;

   state_t        r_state, w_stateNext;
   logic [DW-1:0] r_dwell, w_dwellNext;
   logic [CW-1:0] r_dbCnt, w_dbNext;
   logic [3:0]    r_row, w_rowNext;
   logic [3:0]    r_pattern, w_patNext;
   logic [3:0]    r_buf, w_bufNext;
   logic          r_valid, w_validNext;
   logic          r_down, w_downNext;
   logic [3:0]    w_cs;
   logic [3:0]    w_rowRot;
   logic [1:0]    w_rowIdx;
   logic [1:0]    w_colIdx;

`ifdef KEYPAD_COLSYNC_EN
   logic [3:0] r_colSync1, r_colSync2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_colSync1 <= 4'hF;
         r_colSync2 <= 4'hF;
      end else begin
         r_colSync1 <= keypadCol;
         r_colSync2 <= r_colSync1;
      end
   end

   assign w_cs = r_colSync2;
`else
   assign w_cs = keypadCol;
`endif

   assign w_rowRot = {r_row[2:0], r_row[3]};

   // Key code is {row, column}; the lowest closed column wins.
   always_comb begin
      w_rowIdx = 2'd0;
      case (r_row)
         4'b1101: w_rowIdx = 2'd1;
         4'b1011: w_rowIdx = 2'd2;
         4'b0111: w_rowIdx = 2'd3;
         default: w_rowIdx = 2'd0;
      endcase
      if (!r_pattern[0])      w_colIdx = 2'd0;
      else if (!r_pattern[1]) w_colIdx = 2'd1;
      else if (!r_pattern[2]) w_colIdx = 2'd2;
      else                    w_colIdx = 2'd3;
   end

   always_comb begin
      w_stateNext = r_state;
      w_dwellNext = r_dwell;
      w_dbNext    = r_dbCnt;
      w_rowNext   = r_row;
      w_patNext   = r_pattern;
      w_bufNext   = r_buf;
      w_validNext = 1'b0;
      w_downNext  = r_down;
      case (r_state)
         S_SCAN: begin
            if (r_dwell == DWELL_LAST) begin
               w_dwellNext = '0;
               if (w_cs == 4'hF) begin
                  w_rowNext = w_rowRot;
               end else begin
                  w_patNext   = w_cs;
                  w_dbNext    = '0;
                  w_stateNext = S_PRESS_DB;
               end
            end else begin
               w_dwellNext = r_dwell + DW'(1);
            end
         end
         S_PRESS_DB: begin
            if (r_dbCnt == DB_DONE) begin
               w_bufNext   = {w_rowIdx, w_colIdx};
               w_validNext = 1'b1;
               w_downNext  = 1'b1;
               w_dbNext    = '0;
               w_stateNext = S_HOLD;
            end else if (w_cs != r_pattern) begin
               w_rowNext   = w_rowRot;
               w_dwellNext = '0;
               w_dbNext    = '0;
               w_stateNext = S_SCAN;
            end else begin
               w_dbNext = r_dbCnt + CW'(1);
            end
         end
         S_HOLD: begin
            if (w_cs == 4'hF) begin
               w_dbNext    = '0;
               w_stateNext = S_REL_DB;
            end
         end
         S_REL_DB: begin
            if (r_dbCnt == DB_DONE) begin
               w_downNext  = 1'b0;
               w_rowNext   = w_rowRot;
               w_dwellNext = '0;
               w_dbNext    = '0;
               w_stateNext = S_SCAN;
            end else if (w_cs != 4'hF) begin
               w_dbNext    = '0;
               w_stateNext = S_HOLD;
            end else begin
               w_dbNext = r_dbCnt + CW'(1);
            end
         end
         default: w_stateNext = S_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_SCAN;
         r_dwell   <= '0;
         r_dbCnt   <= '0;
         r_row     <= 4'b1110;
         r_pattern <= 4'hF;
         r_buf     <= 4'h0;
         r_valid   <= 1'b0;
         r_down    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_dwell   <= w_dwellNext;
         r_dbCnt   <= w_dbNext;
         r_row     <= w_rowNext;
         r_pattern <= w_patNext;
         r_buf     <= w_bufNext;
         r_valid   <= w_validNext;
         r_down    <= w_downNext;
      end
   end

   assign keypadRow = r_row;
   assign keypadBuf = r_buf;
   assign key_valid = r_valid;
   assign key_down  = r_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model plus a key-code scoreboard.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] keypadCol;
   logic [3:0] keypadRow;
   logic [3:0] keypadBuf;
   logic       key_valid;
   logic       key_down;

   logic       keyOn;
   logic [1:0] keyRow;
   logic [3:0] keyMask;
   logic [3:0] expCode;

   int total = 0;
   int bad = 0;
   int validCount = 0;
   logic [3:0] expQ[$];

   keypad_scanner #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .keypadCol(keypadCol),
      .keypadRow(keypadRow),
      .keypadBuf(keypadBuf),
      .key_valid(key_valid),
      .key_down (key_down)
   );

   always #5 clk = ~clk;

   // Matrix model: closed keys of the held row pull columns low only while that row is driven.
   assign keypadCol = (keyOn && keypadRow[keyRow] == 1'b0) ? ~keyMask : 4'hF;

   // Scoreboard: every strobe must match the next queued key code.
   always @(negedge clk) begin
      if (rst === 1'b1 && key_valid === 1'b1) begin
         validCount++;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL strobe_unexpected: keypadBuf=%0d, required no strobe", keypadBuf);
         end else begin
            expCode = expQ.pop_front();
            if (keypadBuf !== expCode) begin
               bad++;
               $display("[TB] FAIL strobe_code: keypadBuf=%0d, required %0d", keypadBuf, expCode);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      keyOn = 1'b1; keyRow = 2'd0; keyMask = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         total += 4;
         if (keypadRow !== 4'b1110) begin bad++; $display("[TB] FAIL reset_row: got %b, required 1110", keypadRow); end
         if (keypadBuf !== 4'h0) begin bad++; $display("[TB] FAIL reset_buf: got %0d, required 0", keypadBuf); end
         if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b, required 0", key_valid); end
         if (key_down !== 1'b0) begin bad++; $display("[TB] FAIL reset_down: got %b, required 0", key_down); end
      end
      rst = 1'b1;
      keyOn = 1'b0;
   endtask

   task automatic test_idle_sweep();
      int v0;
      logic [3:0] expRow;
      v0 = validCount;
      for (int k = 1; k < 20; k++) begin
         tick();
         expRow = ~(4'b0001 << ((k / SCAN_DIV) % 4));
         total++;
         if (keypadRow !== expRow) begin
            bad++;
            $display("[TB] FAIL idle_row[%0d]: got %b, required %b", k, keypadRow, expRow);
         end
      end
      total++;
      if (validCount != v0) begin bad++; $display("[TB] FAIL idle_strobes: got %0d, required 0", validCount - v0); end
   endtask

   task automatic test_clean_press();
      int v0;
      keyRow = 2'd2; keyMask = 4'b0010; keyOn = 1'b1;
      expQ.push_back(4'd9);
      v0 = validCount;
      repeat (50) tick();
      total += 4;
      if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL press_strobes: got %0d, required 1", validCount - v0); end
      if (keypadRow !== 4'b1011) begin bad++; $display("[TB] FAIL press_row: got %b, required 1011", keypadRow); end
      if (keypadBuf !== 4'd9) begin bad++; $display("[TB] FAIL press_buf: got %0d, required 9", keypadBuf); end
      if (key_down !== 1'b1) begin bad++; $display("[TB] FAIL press_down: got %b, required 1", key_down); end
      keyOn = 1'b0;
      repeat (DEBOUNCE_CNT + 1) tick();
      total++;
      if (key_down !== 1'b1) begin bad++; $display("[TB] FAIL release_early: key_down=%b, required 1", key_down); end
      tick();
      total += 3;
      if (key_down !== 1'b0) begin bad++; $display("[TB] FAIL release_down: got %b, required 0", key_down); end
      if (keypadRow !== 4'b0111) begin bad++; $display("[TB] FAIL release_row: got %b, required 0111", keypadRow); end
      if (expQ.size() != 0) begin bad++; $display("[TB] FAIL press_queue: %0d left, required 0", expQ.size()); end
   endtask

   task automatic test_bounce();
      int v0;
      int n;
      keyRow = 2'd0; keyMask = 4'b0100; keyOn = 1'b1;
      v0 = validCount;
      n = 0;
      do begin
         tick();
         n++;
      end while (keypadRow !== 4'b1110 && n < 20);
      total++;
      if (keypadRow !== 4'b1110) begin bad++; $display("[TB] FAIL bounce_wait_row0: row=%b, required 1110", keypadRow); end
      repeat (SCAN_DIV + 5) tick();
      keyOn = 1'b0;
      tick();
      total += 3;
      if (keypadRow !== 4'b1101) begin bad++; $display("[TB] FAIL bounce_row: got %b, required 1101", keypadRow); end
      if (keypadBuf !== 4'd9) begin bad++; $display("[TB] FAIL bounce_buf: got %0d, required 9", keypadBuf); end
      if (key_down !== 1'b0) begin bad++; $display("[TB] FAIL bounce_down: got %b, required 0", key_down); end
      repeat (12) tick();
      total++;
      if (validCount != v0) begin bad++; $display("[TB] FAIL bounce_strobes: got %0d, required 0", validCount - v0); end
   endtask

   task automatic test_multi_col();
      int v0;
      int n;
      keyRow = 2'd1; keyMask = 4'b1001; keyOn = 1'b1;
      expQ.push_back(4'd4);
      v0 = validCount;
      n = 0;
      while (key_down !== 1'b1 && n < 60) begin tick(); n++; end
      total += 3;
      if (key_down !== 1'b1) begin bad++; $display("[TB] FAIL multi_timeout: key_down=%b, required 1", key_down); end
      if (keypadBuf !== 4'd4) begin bad++; $display("[TB] FAIL multi_buf: got %0d, required 4", keypadBuf); end
      if (keypadRow !== 4'b1101) begin bad++; $display("[TB] FAIL multi_row: got %b, required 1101", keypadRow); end
      keyOn = 1'b0;
      repeat (4) tick();
      keyOn = 1'b1;
      repeat (3) tick();
      total++;
      if (key_down !== 1'b1) begin bad++; $display("[TB] FAIL relbounce_down: got %b, required 1", key_down); end
      keyOn = 1'b0;
      repeat (DEBOUNCE_CNT + 1) tick();
      total++;
      if (key_down !== 1'b1) begin bad++; $display("[TB] FAIL relbounce_early: key_down=%b, required 1", key_down); end
      tick();
      total += 4;
      if (key_down !== 1'b0) begin bad++; $display("[TB] FAIL multi_release: key_down=%b, required 0", key_down); end
      if (keypadRow !== 4'b1011) begin bad++; $display("[TB] FAIL multi_next_row: got %b, required 1011", keypadRow); end
      if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL multi_strobes: got %0d, required 1", validCount - v0); end
      if (expQ.size() != 0) begin bad++; $display("[TB] FAIL multi_queue: %0d left, required 0", expQ.size()); end
   endtask

   task automatic test_reset_in_hold();
      int n;
      keyRow = 2'd3; keyMask = 4'b1000; keyOn = 1'b1;
      expQ.push_back(4'd15);
      n = 0;
      while (key_down !== 1'b1 && n < 60) begin tick(); n++; end
      total += 2;
      if (key_down !== 1'b1) begin bad++; $display("[TB] FAIL hold_timeout: key_down=%b, required 1", key_down); end
      if (keypadBuf !== 4'd15) begin bad++; $display("[TB] FAIL hold_buf: got %0d, required 15", keypadBuf); end
      rst = 1'b0;
      tick();
      total += 4;
      if (keypadBuf !== 4'h0) begin bad++; $display("[TB] FAIL hold_reset_buf: got %0d, required 0", keypadBuf); end
      if (key_down !== 1'b0) begin bad++; $display("[TB] FAIL hold_reset_down: got %b, required 0", key_down); end
      if (keypadRow !== 4'b1110) begin bad++; $display("[TB] FAIL hold_reset_row: got %b, required 1110", keypadRow); end
      if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_reset_valid: got %b, required 0", key_valid); end
      rst = 1'b1;
      keyOn = 1'b0;
      tick();
      total++;
      if (expQ.size() != 0) begin bad++; $display("[TB] FAIL hold_queue: %0d left, required 0", expQ.size()); end
   endtask

   initial begin
      rst = 1'b0;
      keyOn = 1'b0;
      keyRow = 2'd0;
      keyMask = 4'h0;
      test_reset();
      test_idle_sweep();
      test_clean_press();
      test_bounce();
      test_multi_col();
      test_reset_in_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
